// File: rtl/cipher_pipe.sv
// Multi-lane stream cipher: Caesar letter shift, 8-bit permutation, rotating-key XOR; decrypt runs the inverse.
// Optional CIPHER_STATS_EN adds a saturating handed-off beat counter output (beat_cnt).
module cipher_pipe #(
  parameter int unsigned LANES = 4,
  parameter int unsigned NKEYS = 3,
  parameter int unsigned KW    = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               mode,
  input  logic [1:0]         direction,
  input  logic [4:0]         shift_num,
  input  logic               seq_clr,
  input  logic               cfg_we,
  input  logic [KW-1:0]      cfg_addr,
  input  logic [7:0]         cfg_key,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] dout,
  output logic [KW-1:0]      key_idx
`ifdef CIPHER_STATS_EN
  ,
  output logic [15:0]        beat_cnt
`endif
);

  localparam int unsigned DW = 8 * LANES;

  // Reset contents of the key table.
  function automatic logic [7:0] key_rst(input int unsigned i);
    case (i)
      0:       return 8'h3E;
      1:       return 8'h49;
      2:       return 8'h7E;
      default: return 8'h00;
    endcase
  endfunction

  // Additive inverse modulo 26 of a right-shift amount.
  function automatic logic [4:0] neg26(input logic [4:0] r);
    return (r == 5'd0) ? 5'd0 : 5'(5'd26 - r);
  endfunction

  // Right-rotate a letter by r (0..25) within its own case; non-letters pass.
  function automatic logic [7:0] shift_byte(input logic [7:0] c, input logic [4:0] r);
    logic [7:0] base;
    logic [5:0] sum;
    base = 8'h41;
    sum  = 6'd0;
    if (c >= 8'h41 && c <= 8'h5A) base = 8'h41;
    else if (c >= 8'h61 && c <= 8'h7A) base = 8'h61;
    else return c;
    sum = 6'(c - base) + 6'(r);
    if (sum >= 6'd26) sum = sum - 6'd26;
    return base + 8'(sum);
  endfunction

  function automatic logic [7:0] permute(input logic [7:0] c);
    return {c[0], c[5], c[2], c[6], c[7], c[4], c[3], c[1]};
  endfunction

  function automatic logic [7:0] inv_permute(input logic [7:0] p);
    logic [7:0] c;
    c[0] = p[7];
    c[5] = p[6];
    c[2] = p[5];
    c[6] = p[4];
    c[7] = p[3];
    c[4] = p[2];
    c[3] = p[1];
    c[1] = p[0];
    return c;
  endfunction

  logic          stall, accept;
  logic [KW-1:0] beat_kidx;
  logic [4:0]    amt, rsh_in;

  logic [7:0]    key_q [NKEYS];
  logic [7:0]    key_d [NKEYS];
  logic [KW-1:0] ptr_q, ptr_d;

  logic          s1_v_q, s1_v_d, s1_mode_q, s1_mode_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [4:0]    s1_rsh_q, s1_rsh_d;
  logic [KW-1:0] s1_kidx_q, s1_kidx_d;

  logic          s2_v_q, s2_v_d, s2_mode_q, s2_mode_d;
  logic [DW-1:0] s2_data_q, s2_data_d;
  logic [4:0]    s2_rsh_q, s2_rsh_d;
  logic [KW-1:0] s2_kidx_q, s2_kidx_d;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [KW-1:0] key_idx_q, key_idx_d;

  // Handshake and per-beat sideband capture.
  always_comb begin
    stall     = out_valid_q && !out_ready;
    in_ready  = !stall;
    accept    = in_valid && !stall;
    beat_kidx = seq_clr ? '0 : ptr_q;
    amt       = (shift_num >= 5'd26) ? 5'(shift_num - 5'd26) : shift_num;
    case (direction)
      2'b10:   rsh_in = amt;
      2'b01:   rsh_in = neg26(amt);
      default: rsh_in = 5'd0;
    endcase
    if (mode) rsh_in = neg26(rsh_in);
  end

  // Key pointer and key table.
  always_comb begin
    ptr_d = ptr_q;
    key_d = key_q;
    if (accept) begin
      if (beat_kidx == KW'(NKEYS - 1)) ptr_d = '0;
      else ptr_d = beat_kidx + KW'(1);
    end else if (seq_clr) begin
      ptr_d = '0;
    end
    if (cfg_we && (32'(cfg_addr) < NKEYS)) key_d[cfg_addr] = cfg_key;
  end

  // Three-stage datapath; every stage holds while the output is stalled.
  always_comb begin
    s1_v_d      = s1_v_q;
    s1_mode_d   = s1_mode_q;
    s1_data_d   = s1_data_q;
    s1_rsh_d    = s1_rsh_q;
    s1_kidx_d   = s1_kidx_q;
    s2_v_d      = s2_v_q;
    s2_mode_d   = s2_mode_q;
    s2_data_d   = s2_data_q;
    s2_rsh_d    = s2_rsh_q;
    s2_kidx_d   = s2_kidx_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    key_idx_d   = key_idx_q;
    if (!stall) begin
      s1_v_d    = accept;
      s1_mode_d = mode;
      s1_rsh_d  = rsh_in;
      s1_kidx_d = beat_kidx;
      for (int unsigned l = 0; l < LANES; l++) begin
        s1_data_d[8*l +: 8] = mode ? (din[8*l +: 8] ^ key_q[beat_kidx])
                                   : shift_byte(din[8*l +: 8], rsh_in);
      end

      s2_v_d    = s1_v_q;
      s2_mode_d = s1_mode_q;
      s2_rsh_d  = s1_rsh_q;
      s2_kidx_d = s1_kidx_q;
      for (int unsigned l = 0; l < LANES; l++) begin
        s2_data_d[8*l +: 8] = s1_mode_q ? inv_permute(s1_data_q[8*l +: 8])
                                        : permute(s1_data_q[8*l +: 8]);
      end

      out_valid_d = s2_v_q;
      key_idx_d   = s2_kidx_q;
      for (int unsigned l = 0; l < LANES; l++) begin
        dout_d[8*l +: 8] = s2_mode_q ? shift_byte(s2_data_q[8*l +: 8], s2_rsh_q)
                                     : (s2_data_q[8*l +: 8] ^ key_q[s2_kidx_q]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      for (int unsigned i = 0; i < NKEYS; i++) key_q[i] <= key_rst(i);
      ptr_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_data_q   <= '0;
      s1_rsh_q    <= '0;
      s1_kidx_q   <= '0;
      s2_v_q      <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_data_q   <= '0;
      s2_rsh_q    <= '0;
      s2_kidx_q   <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      key_idx_q   <= '0;
    end else begin
      key_q       <= key_d;
      ptr_q       <= ptr_d;
      s1_v_q      <= s1_v_d;
      s1_mode_q   <= s1_mode_d;
      s1_data_q   <= s1_data_d;
      s1_rsh_q    <= s1_rsh_d;
      s1_kidx_q   <= s1_kidx_d;
      s2_v_q      <= s2_v_d;
      s2_mode_q   <= s2_mode_d;
      s2_data_q   <= s2_data_d;
      s2_rsh_q    <= s2_rsh_d;
      s2_kidx_q   <= s2_kidx_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      key_idx_q   <= key_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign key_idx   = key_idx_q;

`ifdef CIPHER_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating count of beats handed downstream.
  always_comb begin
    cnt_d = cnt_q;
    if (seq_clr) cnt_d = 16'h0000;
    else if (out_valid_q && out_ready && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'h0001;
  end

  always_ff @(posedge clock) begin
    if (rst) cnt_q <= 16'h0000;
    else cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cipher_pipe.sv
// Directed bench for cipher_pipe (default LANES=4, NKEYS=3): hand-computed vectors plus a
// backpressure run checked against a small behavioural cipher model.
module tb_cipher_pipe;

  localparam int unsigned LANES = 4;
  localparam int unsigned NKEYS = 3;
  localparam int unsigned KW    = 2;

  logic               clock = 1'b0;
  logic               rst = 1'b1;
  logic               mode = 1'b0;
  logic [1:0]         direction = 2'b00;
  logic [4:0]         shift_num = 5'd0;
  logic               seq_clr = 1'b0;
  logic               cfg_we = 1'b0;
  logic [KW-1:0]      cfg_addr = '0;
  logic [7:0]         cfg_key = 8'h00;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [8*LANES-1:0] din = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [8*LANES-1:0] dout;
  logic [KW-1:0]      key_idx;
`ifdef CIPHER_STATS_EN
  logic [15:0]        beat_cnt;
`endif

  cipher_pipe #(.LANES(LANES), .NKEYS(NKEYS)) dut (
    .clock(clock), .rst(rst), .mode(mode), .direction(direction), .shift_num(shift_num),
    .seq_clr(seq_clr), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_key(cfg_key),
    .in_valid(in_valid), .in_ready(in_ready), .din(din), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .key_idx(key_idx)
`ifdef CIPHER_STATS_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]   d;
    logic [KW-1:0] k;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad = 0;
  logic bp_en = 1'b0;
  int   tb_ptr = 0;
  logic [7:0] tb_keys [NKEYS] = '{8'h3E, 8'h49, 8'h7E};
  localparam int SRC [8] = '{1, 3, 4, 7, 6, 2, 5, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_shift(input logic [7:0] c, input int r);
    int base;
    if (c >= 8'h41 && c <= 8'h5A) base = 65;
    else if (c >= 8'h61 && c <= 8'h7A) base = 97;
    else return c;
    return 8'((((int'(c) - base + r) % 26) + 26) % 26 + base);
  endfunction

  function automatic logic [7:0] m_perm(input logic [7:0] c);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = c[SRC[i]];
    return p;
  endfunction

  function automatic logic [7:0] m_iperm(input logic [7:0] p);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) c[SRC[i]] = p[i];
    return c;
  endfunction

  function automatic logic [31:0] m_beat(input logic m, input logic [1:0] dr, input logic [4:0] sh,
                                         input logic [31:0] d, input logic [7:0] key);
    int r;
    logic [31:0] o;
    r = (dr == 2'b10) ? int'(sh) % 26 : (dr == 2'b01) ? -(int'(sh) % 26) : 0;
    if (m) r = -r;
    for (int l = 0; l < 4; l++)
      o[8*l +: 8] = m ? m_shift(m_iperm(d[8*l +: 8] ^ key), r)
                      : (m_perm(m_shift(d[8*l +: 8], r)) ^ key);
    return o;
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Present one beat until accepted; the expected result is queued for the output monitor.
  task automatic send(input logic m, input logic [1:0] dr, input logic [4:0] sh, input logic [31:0] d,
                      input logic sc, input logic [31:0] ed, input logic [KW-1:0] ek);
    int   guard;
    logic acc;
    exp_q.push_back('{d: ed, k: ek});
    tb_ptr = sc ? 0 : tb_ptr;
    tb_ptr = (tb_ptr == NKEYS - 1) ? 0 : tb_ptr + 1;
    mode = m; direction = dr; shift_num = sh; din = d; seq_clr = sc; in_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      acc = in_ready;
      tick();
      guard++;
      if (!acc && guard > 1000) begin
        chk("send_timeout", 32'(1), 32'(0));
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
    seq_clr  = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      tick();
      g++;
    end
    chk("drain", 32'(exp_q.size()), 32'(0));
  endtask

  // Random backpressure; changes just after the edge so the bench samples settled values.
  always @(posedge clock) begin
    #1;
    if (bp_en) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: in-order scoreboard plus in_ready/stall relationship.
  always @(negedge clock) begin
    exp_t e;
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("dout", dout, e.d);
          chk("key_idx", 32'(key_idx), 32'(e.k));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] d, ed;
    logic        m;
    logic [1:0]  dr;
    logic [4:0]  sh;
    int          k;

    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_dout", dout, 32'(0));
    chk("rst_key_idx", 32'(key_idx), 32'(0));
    rst = 1'b0;
    tick();

    // 'A' right 3, key 0 -> 0x0E; out_valid on the third edge counting the accept edge.
    send(1'b0, 2'b10, 5'd3, {4{8'h41}}, 1'b0, {4{8'h0E}}, 2'd0);
    chk("lat_edge1", 32'(out_valid), 32'(0));
    tick();
    chk("lat_edge2", 32'(out_valid), 32'(0));
    tick();
    chk("lat_edge3", 32'(out_valid), 32'(1));
    wait_drain();

    // 'z' right 1 wraps to 'a', key 0 -> 0xEE.
    send(1'b0, 2'b10, 5'd1, {4{8'h7A}}, 1'b1, {4{8'hEE}}, 2'd0);
    wait_drain();

    // Key rotation, back-to-back, no shift.
    send(1'b0, 2'b00, 5'd0, {4{8'h35}}, 1'b1, {4{8'hDA}}, 2'd0);
    send(1'b0, 2'b00, 5'd0, {4{8'h35}}, 1'b0, {4{8'hAD}}, 2'd1);
    send(1'b0, 2'b00, 5'd0, {4{8'h35}}, 1'b0, {4{8'h9A}}, 2'd2);
    send(1'b0, 2'b00, 5'd0, {4{8'h35}}, 1'b0, {4{8'hDA}}, 2'd0);
    wait_drain();

    // 'B' left 29 (=3) -> 'Y' -> 0x96 ^ 0x3E = 0xA8, then decrypt back-to-back.
    send(1'b0, 2'b01, 5'd29, {4{8'h42}}, 1'b1, {4{8'hA8}}, 2'd0);
    send(1'b1, 2'b01, 5'd29, {4{8'hA8}}, 1'b1, {4{8'h42}}, 2'd0);
    wait_drain();

    // Mixed random beats under random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      for (int l = 0; l < 4; l++) d[8*l +: 8] = 8'($urandom_range(64, 123));
      m  = 1'($urandom_range(0, 1));
      dr = 2'($urandom_range(0, 3));
      sh = 5'($urandom_range(0, 31));
      k  = tb_ptr;
      ed = m_beat(m, dr, sh, d, tb_keys[k]);
      send(m, dr, sh, d, 1'b0, ed, KW'(k));
    end
    wait_drain();
    bp_en = 1'b0;
    @(posedge clock);
    #3;
    out_ready = 1'b1;
    tick();

    // Key write then restart from index 0.
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_key = 8'hFF;
    tick();
    cfg_we = 1'b0;
    tb_keys[1] = 8'hFF;
    send(1'b0, 2'b00, 5'd0, 32'h0, 1'b1, {4{8'h3E}}, 2'd0);
    send(1'b0, 2'b00, 5'd0, 32'h0, 1'b0, {4{8'hFF}}, 2'd1);
    wait_drain();

    // Reset with a beat in flight: it must vanish and the key table/pointer return to defaults.
    din = {4{8'h41}}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    rst = 1'b0;
    tb_ptr = 0;
    tb_keys[1] = 8'h49;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_quiet", 32'(out_valid), 32'(0));
    end
    send(1'b0, 2'b00, 5'd0, 32'h0, 1'b0, {4{8'h3E}}, 2'd0);
    send(1'b0, 2'b00, 5'd0, 32'h0, 1'b0, {4{8'h49}}, 2'd1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
